score_event_gen: RTL and testbench
==================================

SCORE_EVENT_GEN -- requirements
Module: score_event_gen

Interface
REQ-001 Parameter BIRD_X, default 80, bird left edge in pixels (fixed column).
REQ-002 Parameter BIRD_W, default 16, bird width in pixels.
REQ-003 Parameter BIRD_H, default 16, bird height in pixels.
REQ-004 Parameter PIPE_W, default 32, pipe width in pixels.
REQ-005 Parameter GAP_H, default 96, vertical gap height in pixels.
REQ-006 Parameter FLOOR_Y, default 464, first row of the floor.
REQ-007 Clock and reset SHALL be exactly: reset reset, asynchronous, active-high; clock clk.
REQ-008 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-009 start_btn  input  1  player start button, already synchronised, level.
REQ-010 bird_y  input  10  bird top row, stable around frame_tick.
REQ-011 pipe_x  input  10  pipe left column, unsigned, decreasing; jumps upward on respawn.
REQ-012 gap_y  input  10  gap top row.
REQ-013 score_en  output  1  one-cycle pulse per pipe passed; drives the score counter enable.
REQ-014 collision  output  1  level, high once the bird has died.
REQ-015 playing  output  1  high in state PLAY.
REQ-016 state  output  2  IDLE=00, PLAY=01, DEAD=10.

Function
REQ-017 FSM: IDLE -> PLAY on start_btn rising edge (0 in previous cycle, 1 now); PLAY -> DEAD on a registered hit; DEAD absorbing, left only by reset.
REQ-018 start_btn edges in PLAY or DEAD SHALL be ignored.
REQ-019 Evaluation only on frame_tick in PLAY; frame_tick in IDLE or DEAD changes nothing.
REQ-020 Stage 1 (frame_tick cycle): register bird_y, pipe_x, gap_y. Stage 2: register hit and pass flags. Stage 3: drive outputs. score_en and the transition to DEAD occur exactly 2 clocks after the frame_tick cycle.
REQ-021 All comparisons SHALL use 11-bit unsigned arithmetic; no sum may wrap.
REQ-022 Horizontal overlap: pipe_x < BIRD_X+BIRD_W and pipe_x+PIPE_W > BIRD_X.
REQ-023 Hit: (overlap and (bird_y < gap_y or bird_y+BIRD_H > gap_y+GAP_H)), or bird_y+BIRD_H > FLOOR_Y.
REQ-024 Pass: armed, previous-frame pipe_x+PIPE_W >= BIRD_X, current pipe_x+PIPE_W < BIRD_X.
REQ-025 armed SHALL clear on pass and set when current pipe_x > previous-frame pipe_x (respawn).
REQ-026 The first evaluated frame after entering PLAY SHALL have no valid previous frame: no pass, armed set; hit still evaluated.
REQ-027 Hit and pass in the same frame: hit wins; no score_en pulse.
REQ-028 score_en SHALL be at most one cycle wide and never asserted outside PLAY.
REQ-029 collision SHALL rise in the same cycle state becomes DEAD and stay high until reset.
REQ-030 A frame_tick arriving while a previous evaluation is still in stages 2-3 SHALL be processed normally (fully pipelined, one frame per cycle max).

Reset
REQ-031 Reset asserted (any time, including mid-pipeline) SHALL immediately force state=IDLE, score_en=0, collision=0, playing=0, armed=1, all pipeline registers and the previous-frame values to 0.
REQ-032 Pipeline results in flight at reset SHALL be discarded; no score_en pulse after reset release without a new PLAY frame.

Verification
REQ-033 Reset, start_btn 0->1 -> state=01, playing=1 next cycle; holding start_btn high produces no further transition.
REQ-034 PLAY, bird_y=200, gap_y=180; frames pipe_x=60 then 47 (right edge 92->79) -> one score_en pulse 2 clocks after the second frame_tick; further frames pipe_x=40,30 -> no pulse.
REQ-035 After REQ-034, pipe_x jumps to 600 then decreases to 47 -> second score_en pulse; total two.
REQ-036 PLAY, pipe_x=70, bird_y=100, gap_y=180 -> state=10, collision=1 2 clocks after frame_tick; later frame_ticks and start_btn edges change nothing.
REQ-037 PLAY, bird_y=460 (bottom 476 > 464), no overlap -> DEAD with collision=1; same-frame pass suppressed.
REQ-038 Reset asserted 1 cycle after a passing frame_tick -> no score_en, state=00, all outputs 0.

Source files
------------

// File: rtl/score_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : score_event_gen
// Description : Game-state controller for a side-scrolling bird game.
//               Tracks IDLE / PLAY / DEAD, evaluates bird-versus-pipe and
//               bird-versus-floor collisions once per video frame, and emits a
//               one-cycle score_en pulse each time the bird clears a pipe.
//
//               Pipeline, counted from the cycle in which frame_tick is high:
//                 stage 1 : bird_y / pipe_x / gap_y captured at the end of
//                           the frame_tick cycle
//                 stage 2 : hit / pass flags computed from the stage-1
//                           snapshot and registered straight into the
//                           state / score_en / collision registers
//                 stage 3 : outputs visible, two clocks after frame_tick
//               One new frame may enter every cycle.
//
// Ports       : clk         - clock
//               reset       - asynchronous, active-high reset
//               frame_tick  - one-cycle pulse per video frame
//               start_btn   - synchronised start button (level)
//               bird_y      - bird top row
//               pipe_x      - pipe left column (decreasing, jumps up on respawn)
//               gap_y       - top row of the pipe gap
//               score_en    - one-cycle pulse per pipe passed
//               collision   - high from the cycle the bird dies until reset
//               playing     - high while in PLAY
//               state       - IDLE=00, PLAY=01, DEAD=10
//
// Revision    : 1.0 - initial release
// ============================================================================
module score_event_gen #(
    parameter int BIRD_X  = 80,
    parameter int BIRD_W  = 16,
    parameter int BIRD_H  = 16,
    parameter int PIPE_W  = 32,
    parameter int GAP_H   = 96,
    parameter int FLOOR_Y = 464
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic [9:0] bird_y,
    input  logic [9:0] pipe_x,
    input  logic [9:0] gap_y,
    output logic       score_en,
    output logic       collision,
    output logic       playing,
    output logic [1:0] state
);

    // ------------------------------------------------------------------------
    // Geometry constants, widened to 11 bits so that no sum of a 10-bit
    // coordinate and a dimension can wrap.
    // ------------------------------------------------------------------------
    localparam logic [10:0] c_bird_x  = 11'(BIRD_X);
    localparam logic [10:0] c_bird_w  = 11'(BIRD_W);
    localparam logic [10:0] c_bird_h  = 11'(BIRD_H);
    localparam logic [10:0] c_pipe_w  = 11'(PIPE_W);
    localparam logic [10:0] c_gap_h   = 11'(GAP_H);
    localparam logic [10:0] c_floor_y = 11'(FLOOR_Y);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_score_en;
    logic       w_score_en_nxt;
    logic       r_collision;
    logic       w_collision_nxt;

    // Start button edge detection
    logic       r_start_d;
    logic       w_start_rise;

    // Stage 1 snapshot of the frame's geometry
    logic       r_s1_valid;
    logic [9:0] r_s1_bird_y;
    logic [9:0] r_s1_pipe_x;
    logic [9:0] r_s1_gap_y;

    // Previous-frame history used for pass detection
    logic       r_prev_valid;
    logic [9:0] r_prev_pipe_x;
    logic       r_armed;
    logic       w_armed_nxt;

    // Stage 2 combinational evaluation
    logic [10:0] w_bird_top;
    logic [10:0] w_bird_bot;
    logic [10:0] w_gap_top;
    logic [10:0] w_gap_bot;
    logic [10:0] w_pipe_left;
    logic [10:0] w_pipe_right;
    logic [10:0] w_prev_right;
    logic        w_overlap;
    logic        w_hit;
    logic        w_pass;

    assign w_start_rise = start_btn & ~r_start_d;

    // ------------------------------------------------------------------------
    // Start button history. Resets low, so a button already held when reset
    // is released counts as a fresh press.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_d <= 1'b0;
        end else begin
            r_start_d <= start_btn;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: capture geometry on frame_tick, but only while playing. Ticks
    // in IDLE or DEAD never enter the pipeline.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_bird_y <= '0;
            r_s1_pipe_x <= '0;
            r_s1_gap_y  <= '0;
        end else begin
            r_s1_valid <= frame_tick && (r_state == ST_PLAY);
            if (frame_tick && (r_state == ST_PLAY)) begin
                r_s1_bird_y <= bird_y;
                r_s1_pipe_x <= pipe_x;
                r_s1_gap_y  <= gap_y;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 evaluation, all in 11-bit unsigned arithmetic.
    // ------------------------------------------------------------------------
    assign w_bird_top   = {1'b0, r_s1_bird_y};
    assign w_bird_bot   = w_bird_top + c_bird_h;
    assign w_gap_top    = {1'b0, r_s1_gap_y};
    assign w_gap_bot    = w_gap_top + c_gap_h;
    assign w_pipe_left  = {1'b0, r_s1_pipe_x};
    assign w_pipe_right = w_pipe_left + c_pipe_w;
    assign w_prev_right = {1'b0, r_prev_pipe_x} + c_pipe_w;

    assign w_overlap = (w_pipe_left < (c_bird_x + c_bird_w)) &&
                       (w_pipe_right > c_bird_x);

    assign w_hit = (w_overlap && ((w_bird_top < w_gap_top) ||
                                  (w_bird_bot > w_gap_bot))) ||
                   (w_bird_bot > c_floor_y);

    // A pass is the pipe's right edge crossing the bird's left edge between
    // two consecutive evaluated frames. Without a previous frame (first frame
    // of a game) there is nothing to cross from.
    assign w_pass = r_armed && r_prev_valid &&
                    (w_prev_right >= c_bird_x) &&
                    (w_pipe_right < c_bird_x);

    // armed prevents one pipe from scoring twice: it drops on a pass and only
    // comes back when the pipe respawns to the right (pipe_x increases).
    always_comb begin
        w_armed_nxt = r_armed;
        if (!r_prev_valid) begin
            w_armed_nxt = 1'b1;
        end else if (w_pass) begin
            w_armed_nxt = 1'b0;
        end else if (r_s1_pipe_x > r_prev_pipe_x) begin
            w_armed_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Previous-frame history. Cleared when a new game starts so that the
    // first frame of the game cannot score against stale coordinates.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_valid  <= 1'b0;
            r_prev_pipe_x <= '0;
            r_armed       <= 1'b1;
        end else if ((r_state == ST_IDLE) && w_start_rise) begin
            r_prev_valid  <= 1'b0;
            r_prev_pipe_x <= '0;
            r_armed       <= 1'b1;
        end else if (r_s1_valid && (r_state == ST_PLAY)) begin
            r_prev_valid  <= 1'b1;
            r_prev_pipe_x <= r_s1_pipe_x;
            r_armed       <= w_armed_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and registered outputs. A frame that is still in flight
    // when the bird dies is dropped because the state is no longer PLAY.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_score_en_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (r_s1_valid) begin
                    if (w_hit) begin
                        // Dying outranks scoring in the same frame.
                        w_state_nxt = ST_DEAD;
                    end else if (w_pass) begin
                        w_score_en_nxt = 1'b1;
                    end
                end
            end
            ST_DEAD: begin
                w_state_nxt = ST_DEAD;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_collision_nxt = (w_state_nxt == ST_DEAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_score_en  <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score_en  <= w_score_en_nxt;
            r_collision <= w_collision_nxt;
        end
    end

    assign state     = r_state;
    assign score_en  = r_score_en;
    assign collision = r_collision;
    assign playing   = (r_state == ST_PLAY);

endmodule
`default_nettype wire

// File: tb/tb_score_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_event_gen
// Description : Self-checking bench for score_event_gen. Each driven frame
//               pushes its expected outcome (cycle, score_en, state) into a
//               scoreboard queue; a negedge monitor pops and compares when
//               that cycle arrives and demands score_en=0 on every other
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_event_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start_btn;
    logic [9:0] bird_y;
    logic [9:0] pipe_x;
    logic [9:0] gap_y;
    logic       score_en;
    logic       collision;
    logic       playing;
    logic [1:0] state;

    int n_cmp   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int n_pulse = 0;
    int fid     = 0;

    typedef struct {
        int         cyc;
        int         fid;
        logic       score;
        logic [1:0] st;
    } exp_t;

    exp_t q[$];

    score_event_gen dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .bird_y     (bird_y),
        .pipe_x     (pipe_x),
        .gap_y      (gap_y),
        .score_en   (score_en),
        .collision  (collision),
        .playing    (playing),
        .state      (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (score_en === 1'b1) n_pulse++;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_cmp++;
                n_err++;
                $error("FAIL frame%0d_missed: observed none expected output at cycle %0d", e.fid, e.cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_cmp++;
                assert (score_en === e.score) else begin
                    n_err++;
                    $error("FAIL frame%0d_score_en: observed %0b expected %0b", e.fid, score_en, e.score);
                end
                n_cmp++;
                assert (state === e.st) else begin
                    n_err++;
                    $error("FAIL frame%0d_state: observed %0b expected %0b", e.fid, state, e.st);
                end
                n_cmp++;
                assert (collision === (e.st == 2'b10)) else begin
                    n_err++;
                    $error("FAIL frame%0d_collision: observed %0b expected %0b", e.fid, collision, (e.st == 2'b10));
                end
                n_cmp++;
                assert (playing === (e.st == 2'b01)) else begin
                    n_err++;
                    $error("FAIL frame%0d_playing: observed %0b expected %0b", e.fid, playing, (e.st == 2'b01));
                end
            end else begin
                n_cmp++;
                assert (score_en === 1'b0) else begin
                    n_err++;
                    $error("FAIL stray_score_en at cycle %0d: observed %0b expected 0", cyc, score_en);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame_tick; optionally push its expected outcome two clocks on.
    task automatic frame(input logic [9:0] px, input logic [9:0] by, input logic [9:0] gy,
                         input logic es, input logic [1:0] est, input bit push, input int gap);
        pipe_x     = px;
        bird_y     = by;
        gap_y      = gy;
        frame_tick = 1'b1;
        if (push) begin
            fid++;
            q.push_back('{cyc + 2, fid, es, est});
        end
        step();
        frame_tick = 1'b0;
        repeat (gap) step();
    endtask

    task automatic do_reset();
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        reset      = 1'b1;
        #1;
        chk("reset_state", 10'(state), 10'd0);
        chk("reset_score_en", 10'(score_en), 10'd0);
        chk("reset_collision", 10'(collision), 10'd0);
        chk("reset_playing", 10'(playing), 10'd0);
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic start_game();
        start_btn = 1'b1;
        step();
        chk("start_state", 10'(state), 10'd1);
        chk("start_playing", 10'(playing), 10'd1);
        repeat (3) step();
        chk("start_held_state", 10'(state), 10'd1);
        start_btn = 1'b0;
        step();
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        bird_y     = '0;
        pipe_x     = '0;
        gap_y      = '0;
        step();

        // Reset state and frame_tick in IDLE
        do_reset();
        frame(10'd70, 10'd100, 10'd180, 1'b0, 2'b00, 1'b1, 2);
        chk("idle_tick_state", 10'(state), 10'd0);

        // Start, then scoring with spaced frames
        start_game();
        n_pulse = 0;
        frame(10'd60, 10'd200, 10'd180, 1'b0, 2'b01, 1'b1, 2);
        frame(10'd47, 10'd200, 10'd180, 1'b1, 2'b01, 1'b1, 2);
        frame(10'd40, 10'd200, 10'd180, 1'b0, 2'b01, 1'b1, 2);
        frame(10'd30, 10'd200, 10'd180, 1'b0, 2'b01, 1'b1, 2);
        // Respawn and second pass with back-to-back frames
        frame(10'd600, 10'd200, 10'd180, 1'b0, 2'b01, 1'b1, 0);
        frame(10'd300, 10'd200, 10'd180, 1'b0, 2'b01, 1'b1, 0);
        frame(10'd100, 10'd200, 10'd180, 1'b0, 2'b01, 1'b1, 0);
        frame(10'd60,  10'd200, 10'd180, 1'b0, 2'b01, 1'b1, 0);
        frame(10'd47,  10'd200, 10'd180, 1'b1, 2'b01, 1'b1, 0);
        repeat (4) step();
        chk("total_pulses", 10'(n_pulse), 10'd2);

        // Pipe collision, then DEAD is absorbing
        do_reset();
        start_game();
        frame(10'd70, 10'd100, 10'd180, 1'b0, 2'b10, 1'b1, 2);
        frame(10'd600, 10'd200, 10'd180, 1'b0, 2'b10, 1'b1, 2);
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        chk("dead_state", 10'(state), 10'd2);
        chk("dead_collision", 10'(collision), 10'd1);
        chk("dead_playing", 10'(playing), 10'd0);

        // Floor collision wins over a same-frame pass
        do_reset();
        n_pulse = 0;
        start_game();
        frame(10'd60, 10'd200, 10'd180, 1'b0, 2'b01, 1'b1, 2);
        frame(10'd47, 10'd460, 10'd180, 1'b0, 2'b10, 1'b1, 2);
        repeat (2) step();
        chk("floor_no_pulse", 10'(n_pulse), 10'd0);

        // Reset one cycle after a passing frame discards it
        do_reset();
        n_pulse = 0;
        start_game();
        frame(10'd60, 10'd200, 10'd180, 1'b0, 2'b01, 1'b1, 2);
        frame(10'd47, 10'd200, 10'd180, 1'b0, 2'b01, 1'b0, 0);
        reset = 1'b1;
        #1;
        chk("midpipe_reset_state", 10'(state), 10'd0);
        chk("midpipe_reset_playing", 10'(playing), 10'd0);
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        chk("post_reset_state", 10'(state), 10'd0);
        chk("post_reset_collision", 10'(collision), 10'd0);
        chk("post_reset_pulses", 10'(n_pulse), 10'd0);

        chk("queue_drained", 10'(q.size()), 10'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
